// File: rtl/exe_stage_mc_if.sv
// EX-stage bundle: instruction operands and controls in, registered EX/MEM fields out.
// The master side drives the instruction and pipeline controls; the slave side is the EX stage.
interface exe_stage_mc_if #(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 4
) ();
  logic                freeze;
  logic                flush;
  logic                in_valid;
  logic                wb_en_in;
  logic                mem_r_en_in;
  logic                mem_w_en_in;
  logic                status_w_en_in;
  logic [2:0]          exe_cmd;
  logic [REG_ADDR-1:0] dest_in;
  logic [WIDTH-1:0]    val_Rn;
  logic [WIDTH-1:0]    val_Rm;
  logic [WIDTH-1:0]    imm_in;
  logic [WIDTH-1:0]    MEM_wb_value;
  logic [WIDTH-1:0]    WB_wb_value;
  logic                use_imm;
  logic [1:0]          fwd_sel_src1;
  logic [1:0]          fwd_sel_src2;
  logic [3:0]          status_reg_in;
  logic [WIDTH-1:0]    pc_in;
  logic [23:0]         branch_offset;

  logic [WIDTH-1:0]    branch_address;
  logic                busy;
  logic                out_valid;
  logic                wb_en_out;
  logic                mem_r_en_out;
  logic                mem_w_en_out;
  logic                status_w_en_out;
  logic [WIDTH-1:0]    alu_res_out;
  logic [WIDTH-1:0]    val_Rm_out;
  logic [REG_ADDR-1:0] dest_out;
  logic [3:0]          status_out;

  modport master (
    output freeze, flush, in_valid, wb_en_in, mem_r_en_in, mem_w_en_in, status_w_en_in,
           exe_cmd, dest_in, val_Rn, val_Rm, imm_in, MEM_wb_value, WB_wb_value, use_imm,
           fwd_sel_src1, fwd_sel_src2, status_reg_in, pc_in, branch_offset,
    input  branch_address, busy, out_valid, wb_en_out, mem_r_en_out, mem_w_en_out,
           status_w_en_out, alu_res_out, val_Rm_out, dest_out, status_out
  );

  modport slave (
    input  freeze, flush, in_valid, wb_en_in, mem_r_en_in, mem_w_en_in, status_w_en_in,
           exe_cmd, dest_in, val_Rn, val_Rm, imm_in, MEM_wb_value, WB_wb_value, use_imm,
           fwd_sel_src1, fwd_sel_src2, status_reg_in, pc_in, branch_offset,
    output branch_address, busy, out_valid, wb_en_out, mem_r_en_out, mem_w_en_out,
           status_w_en_out, alu_res_out, val_Rm_out, dest_out, status_out
  );
endinterface

// File: rtl/exe_stage_mc.sv
// Execute stage with single-cycle ALU ops and a WIDTH-cycle radix-2 shift-add multiplier.
// Multiplies stall upstream through busy; the EX/MEM output register honours freeze and flush.
module exe_stage_mc #(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 4
) (
  input logic           clk,
  input logic           rst,
  exe_stage_mc_if.slave ex_io
);
  localparam logic [2:0] CMD_MOV = 3'b000;
  localparam logic [2:0] CMD_ADD = 3'b001;
  localparam logic [2:0] CMD_SUB = 3'b010;
  localparam logic [2:0] CMD_AND = 3'b011;
  localparam logic [2:0] CMD_ORR = 3'b100;
  localparam logic [2:0] CMD_EOR = 3'b101;
  localparam logic [2:0] CMD_MUL = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0]    acc_q, mcand_q, mplier_q;
  logic [REG_ADDR-1:0] m_dest_q;
  logic [WIDTH-1:0]    m_rm_q;
  logic [3:0]          m_ctl_q;
  logic [1:0]          m_cv_q;

  logic                ov_q, ov_d;
  logic [3:0]          en_q, en_d;
  logic [WIDTH-1:0]    res_q, res_d;
  logic [WIDTH-1:0]    rm_q, rm_d;
  logic [REG_ADDR-1:0] dest_q, dest_d;
  logic [3:0]          st_q, st_d;

  logic [WIDTH-1:0]    op1, fwd_rm, op2;
  logic [WIDTH+3:0]    alu_out;
  logic [3:0]          ctl_in;
  logic                is_mul, mul_start;

  logic signed [25:0]  off_sh;
  logic [WIDTH+25:0]   off_ext;
  logic                unused_bits;

  function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0]       sel,
                                               input logic [WIDTH-1:0] reg_v,
                                               input logic [WIDTH-1:0] wb_v,
                                               input logic [WIDTH-1:0] mem_v);
    logic [WIDTH-1:0] v;
    case (sel)
      2'b01:   v = wb_v;
      2'b10:   v = mem_v;
      default: v = reg_v;
    endcase
    return v;
  endfunction

  // Returns {N, Z, C, V, result}; logic ops pass C/V through from the current status.
  function automatic logic [WIDTH+3:0] alu_op(input logic [2:0]       cmd,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0]       cv);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c, v;
    sum = '0;
    r   = a;
    c   = cv[1];
    v   = cv[0];
    case (cmd)
      CMD_MOV: r = b;
      CMD_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      CMD_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      CMD_AND: r = a & b;
      CMD_ORR: r = a | b;
      CMD_EOR: r = a ^ b;
      default: r = a;
    endcase
    return {r[WIDTH-1], (r == '0), c, v, r};
  endfunction

  assign op1     = fwd_mux(ex_io.fwd_sel_src1, ex_io.val_Rn, ex_io.WB_wb_value, ex_io.MEM_wb_value);
  assign fwd_rm  = fwd_mux(ex_io.fwd_sel_src2, ex_io.val_Rm, ex_io.WB_wb_value, ex_io.MEM_wb_value);
  assign op2     = ex_io.use_imm ? ex_io.imm_in : fwd_rm;
  assign alu_out = alu_op(ex_io.exe_cmd, op1, op2, ex_io.status_reg_in[1:0]);
  assign ctl_in  = {ex_io.wb_en_in, ex_io.mem_r_en_in, ex_io.mem_w_en_in, ex_io.status_w_en_in};
  assign is_mul  = (ex_io.exe_cmd == CMD_MUL);

  assign mul_start = (state_q == S_IDLE) && ex_io.in_valid && is_mul && !ex_io.flush;

  assign ex_io.busy = ((state_q == S_IDLE) && ex_io.in_valid && is_mul) ||
                      (state_q == S_MUL) ||
                      ((state_q == S_DONE) && ex_io.freeze);

  // Word offset sign-extended past any WIDTH, then wrapped to WIDTH bits.
  assign off_sh              = {ex_io.branch_offset, 2'b00};
  assign off_ext             = {{WIDTH{off_sh[25]}}, off_sh};
  assign ex_io.branch_address = ex_io.pc_in + off_ext[WIDTH-1:0];
  assign unused_bits          = ^{ex_io.status_reg_in[3:2], off_ext[WIDTH+25:WIDTH]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ex_io.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (ex_io.in_valid && is_mul) begin
          state_d = S_MUL;
          cnt_d   = '0;
        end
        S_MUL: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_DONE;
        end
        S_DONE: if (!ex_io.freeze) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Multiplier datapath: operands captured on accept, one shift-add step per MUL cycle.
  always_ff @(posedge clk) begin
    if (mul_start) begin
      acc_q    <= '0;
      mcand_q  <= op1;
      mplier_q <= op2;
      m_dest_q <= ex_io.dest_in;
      m_rm_q   <= fwd_rm;
      m_ctl_q  <= ctl_in;
      m_cv_q   <= ex_io.status_reg_in[1:0];
    end else if (state_q == S_MUL) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  // EX/MEM output register: freeze holds everything, otherwise a bubble unless a result is ready.
  always_comb begin
    ov_d   = ov_q;
    en_d   = en_q;
    res_d  = res_q;
    rm_d   = rm_q;
    dest_d = dest_q;
    st_d   = st_q;
    if (!ex_io.freeze) begin
      ov_d = 1'b0;
      en_d = '0;
      if (!ex_io.flush) begin
        if ((state_q == S_IDLE) && ex_io.in_valid && !is_mul) begin
          ov_d   = 1'b1;
          en_d   = ctl_in;
          res_d  = alu_out[WIDTH-1:0];
          rm_d   = fwd_rm;
          dest_d = ex_io.dest_in;
          st_d   = alu_out[WIDTH+3:WIDTH];
        end else if (state_q == S_DONE) begin
          ov_d   = 1'b1;
          en_d   = m_ctl_q;
          res_d  = acc_q;
          rm_d   = m_rm_q;
          dest_d = m_dest_q;
          st_d   = {acc_q[WIDTH-1], (acc_q == '0), m_cv_q};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q   <= 1'b0;
      en_q   <= '0;
      res_q  <= '0;
      rm_q   <= '0;
      dest_q <= '0;
      st_q   <= '0;
    end else begin
      ov_q   <= ov_d;
      en_q   <= en_d;
      res_q  <= res_d;
      rm_q   <= rm_d;
      dest_q <= dest_d;
      st_q   <= st_d;
    end
  end

  assign ex_io.out_valid       = ov_q;
  assign ex_io.wb_en_out       = en_q[3];
  assign ex_io.mem_r_en_out    = en_q[2];
  assign ex_io.mem_w_en_out    = en_q[1];
  assign ex_io.status_w_en_out = en_q[0];
  assign ex_io.alu_res_out     = res_q;
  assign ex_io.val_Rm_out      = rm_q;
  assign ex_io.dest_out        = dest_q;
  assign ex_io.status_out      = st_q;
endmodule

// File: tb/tb_exe_stage_mc.sv
// Bench for exe_stage_mc: arithmetic reference model with a multiply countdown, checked every
// cycle, plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_exe_stage_mc;
  localparam int W  = 32;
  localparam int RA = 4;
  localparam logic [2:0] MOV = 3'd0, ADD = 3'd1, SUB = 3'd2, ANDC = 3'd3,
                         ORR = 3'd4, EOR = 3'd5, MUL = 3'd6, PASS = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  exe_stage_mc_if #(.WIDTH(W), .REG_ADDR(RA)) bus ();
  exe_stage_mc #(.WIDTH(W), .REG_ADDR(RA)) dut (.clk(clk), .rst(rst), .ex_io(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model state: visible output register and a pending multiply.
  logic        m_valid;
  logic [3:0]  m_en, m_dest, m_st;
  logic [31:0] m_res, m_rm;
  logic        p_on;
  int          p_left;
  logic [31:0] p_prod, p_rm;
  logic [3:0]  p_dest, p_en;
  logic [1:0]  p_cv;

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r);
    if (s == 2'b01) return bus.WB_wb_value;
    if (s == 2'b10) return bus.MEM_wb_value;
    return r;
  endfunction

  function automatic logic [35:0] ref_alu(input logic [2:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] st);
    longint sa, sb, s;
    logic [31:0] r;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = st[1];
    v = st[0];
    r = a;
    case (cmd)
      MOV:  r = b;
      ADD: begin
        r = a + b;
        c = (longint'(a) + longint'(b)) >= 64'sd4294967296;
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      SUB: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ANDC: r = a & b;
      ORR:  r = a | b;
      EOR:  r = a ^ b;
      default: r = a;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [31:0] a, b, rm;
    logic [35:0] o;
    if (rst) begin
      m_valid = 0; m_en = 0; m_dest = 0; m_st = 0; m_res = 0; m_rm = 0;
      p_on = 0; p_left = 0;
    end else begin
      a  = pick(bus.fwd_sel_src1, bus.val_Rn);
      rm = pick(bus.fwd_sel_src2, bus.val_Rm);
      b  = bus.use_imm ? bus.imm_in : rm;
      if (bus.flush) begin
        p_on = 0;
        if (!bus.freeze) begin m_valid = 0; m_en = 0; end
      end else if (p_on) begin
        if (p_left > 0) begin
          p_left--;
          if (!bus.freeze) begin m_valid = 0; m_en = 0; end
        end else if (!bus.freeze) begin
          m_valid = 1; m_en = p_en; m_res = p_prod; m_rm = p_rm; m_dest = p_dest;
          m_st = {p_prod[31], (p_prod == 32'd0), p_cv};
          p_on = 0;
        end
      end else if (bus.in_valid && bus.exe_cmd == MUL) begin
        p_on = 1; p_left = W;
        p_prod = 32'(longint'(a) * longint'(b));
        p_rm = rm; p_dest = bus.dest_in; p_cv = bus.status_reg_in[1:0];
        p_en = {bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in, bus.status_w_en_in};
        if (!bus.freeze) begin m_valid = 0; m_en = 0; end
      end else if (bus.in_valid) begin
        if (!bus.freeze) begin
          o = ref_alu(bus.exe_cmd, a, b, bus.status_reg_in);
          m_valid = 1; m_res = o[31:0]; m_st = o[35:32]; m_rm = rm; m_dest = bus.dest_in;
          m_en = {bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in, bus.status_w_en_in};
        end
      end else if (!bus.freeze) begin
        m_valid = 0; m_en = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic exp_busy;
    logic [31:0] exp_ba;
    exp_busy = (!p_on && bus.in_valid && bus.exe_cmd == MUL) || (p_on && (p_left > 0 || bus.freeze));
    exp_ba   = 32'(longint'(bus.pc_in) + longint'($signed(bus.branch_offset)) * 4);
    chk("busy", {63'd0, bus.busy}, {63'd0, exp_busy});
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_valid});
    chk("enables", {60'd0, bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out, bus.status_w_en_out},
        {60'd0, m_en});
    chk("alu_res_out", {32'd0, bus.alu_res_out}, {32'd0, m_res});
    chk("val_Rm_out", {32'd0, bus.val_Rm_out}, {32'd0, m_rm});
    chk("dest_out", {60'd0, bus.dest_out}, {60'd0, m_dest});
    chk("status_out", {60'd0, bus.status_out}, {60'd0, m_st});
    chk("branch_address", {32'd0, bus.branch_address}, {32'd0, exp_ba});
  end

  task automatic present(input logic [2:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [31:0] imm, input logic ui, input logic [1:0] s1,
                         input logic [1:0] s2, input logic [3:0] dest, input logic [3:0] st,
                         input logic [3:0] en);
    bus.in_valid = 1'b1; bus.exe_cmd = cmd; bus.val_Rn = rn; bus.val_Rm = rm; bus.imm_in = imm;
    bus.use_imm = ui; bus.fwd_sel_src1 = s1; bus.fwd_sel_src2 = s2; bus.dest_in = dest;
    bus.status_reg_in = st;
    {bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in, bus.status_w_en_in} = en;
  endtask

  // Hold the instruction until a cycle with busy low has passed its edge.
  task automatic exec(input logic [2:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                      input logic [31:0] imm, input logic ui, input logic [1:0] s1,
                      input logic [1:0] s2, input logic [3:0] dest, input logic [3:0] st,
                      input logic [3:0] en);
    int n;
    logic b;
    present(cmd, rn, rm, imm, ui, s1, s2, dest, st, en);
    b = 1'b1;
    for (n = 0; n < 100 && b; n++) begin
      @(negedge clk);
      b = bus.busy;
      @(posedge clk);
      #1;
    end
    chk("exec_taken", {63'd0, ~b}, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int busy_cnt, first_v, ov_cnt;
    logic [31:0] res_first;
    logic b;
    bus.freeze = 0; bus.flush = 0; bus.in_valid = 0; bus.exe_cmd = MOV;
    bus.wb_en_in = 0; bus.mem_r_en_in = 0; bus.mem_w_en_in = 0; bus.status_w_en_in = 0;
    bus.dest_in = 0; bus.val_Rn = 0; bus.val_Rm = 0; bus.imm_in = 0;
    bus.MEM_wb_value = 0; bus.WB_wb_value = 0; bus.use_imm = 0;
    bus.fwd_sel_src1 = 0; bus.fwd_sel_src2 = 0; bus.status_reg_in = 0;
    bus.pc_in = 32'h0000_1000; bus.branch_offset = 24'hFF_FFFF;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_res", {32'd0, bus.alu_res_out}, 64'd0);
    chk("rst_status", {60'd0, bus.status_out}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("branch_neg", {32'd0, bus.branch_address}, 64'h0000_0FFC);
    @(posedge clk); #1 rst = 1'b0;

    exec(ADD, 32'h7FFF_FFFF, 0, 32'd1, 1, 2'b00, 2'b00, 4'd3, 4'b0000, 4'b1001);
    chk("add_ovf_res", {32'd0, bus.alu_res_out}, 64'h8000_0000);
    chk("add_ovf_st", {60'd0, bus.status_out}, 64'b1001);
    chk("add_ovf_valid", {63'd0, bus.out_valid}, 64'd1);

    bus.MEM_wb_value = 32'd5;
    exec(SUB, 32'd9, 32'd5, 0, 0, 2'b10, 2'b00, 4'd4, 4'b0000, 4'b1000);
    chk("sub_fwd_res", {32'd0, bus.alu_res_out}, 64'd0);
    chk("sub_fwd_st", {60'd0, bus.status_out}, 64'b0110);

    bus.WB_wb_value = 32'd1; bus.pc_in = 32'hFFFF_FFF0; bus.branch_offset = 24'h00_0004;
    exec(ADD, 32'hFFFF_FFFF, 32'd77, 0, 0, 2'b00, 2'b01, 4'd5, 4'b0000, 4'b1100);
    chk("add_carry_st", {60'd0, bus.status_out}, 64'b0110);
    chk("add_carry_rm", {32'd0, bus.val_Rm_out}, 64'd1);
    chk("branch_wrap", {32'd0, bus.branch_address}, 64'd0);
    exec(SUB, 32'd3, 32'd5, 0, 0, 2'b11, 2'b11, 4'd6, 4'b0011, 4'b0001);
    chk("sub_borrow_res", {32'd0, bus.alu_res_out}, 64'hFFFF_FFFE);
    chk("sub_borrow_st", {60'd0, bus.status_out}, 64'b1000);
    exec(SUB, 32'h8000_0000, 0, 32'd1, 1, 2'b00, 2'b00, 4'd7, 4'b0000, 4'b1111);
    chk("sub_ovf_st", {60'd0, bus.status_out}, 64'b0011);
    bus.pc_in = 32'h0000_2000; bus.branch_offset = 24'h00_0100;
    exec(ANDC, 32'h0000_F0F0, 32'h0000_0FF0, 0, 0, 2'b00, 2'b00, 4'd8, 4'b0011, 4'b1000);
    chk("and_res", {32'd0, bus.alu_res_out}, 64'h0000_00F0);
    chk("and_st", {60'd0, bus.status_out}, 64'b0011);
    exec(ORR, 32'h8000_0000, 32'h0000_0001, 0, 0, 2'b00, 2'b00, 4'd9, 4'b0010, 4'b1000);
    exec(EOR, 32'h1234_5678, 0, 32'h1234_5678, 1, 2'b00, 2'b00, 4'd10, 4'b0001, 4'b1000);
    chk("eor_st", {60'd0, bus.status_out}, 64'b0101);
    bus.WB_wb_value = 32'hCAFE_0001;
    exec(MOV, 0, 32'hDEAD_BEEF, 0, 0, 2'b00, 2'b00, 4'd11, 4'b0000, 4'b1000);
    exec(PASS, 32'h1111, 32'h2222, 0, 0, 2'b01, 2'b10, 4'd12, 4'b0000, 4'b1010);
    chk("pass_res", {32'd0, bus.alu_res_out}, 64'hCAFE_0001);
    bus.freeze = 1'b1;
    exec(ADD, 32'd1, 32'd1, 0, 0, 2'b00, 2'b00, 4'd13, 4'b0000, 4'b1000);
    chk("freeze_hold", {32'd0, bus.alu_res_out}, 64'hCAFE_0001);
    bus.freeze = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 7*6: busy count and output latency measured from the accept cycle.
    present(MUL, 32'd7, 32'd6, 0, 0, 2'b00, 2'b00, 4'd2, 4'b0010, 4'b1001);
    busy_cnt = 0; first_v = -1; res_first = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      b = bus.busy;
      if (b) busy_cnt++;
      if (c >= 1 && bus.out_valid && first_v < 0) begin first_v = c; res_first = bus.alu_res_out; end
      @(posedge clk); #1;
      if (!b) bus.in_valid = 1'b0;
    end
    chk("mul_busy_cycles", 64'(busy_cnt), 64'd33);
    chk("mul_latency", 64'(first_v), 64'd34);
    chk("mul_product", {32'd0, res_first}, 64'd42);

    // Flush while the multiply is in progress.
    present(MUL, 32'd9, 32'd9, 0, 0, 2'b00, 2'b00, 4'd1, 4'b0000, 4'b1000);
    ov_cnt = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (c == 11) chk("flush_busy", {63'd0, bus.busy}, 64'd0);
      if (c >= 1 && bus.out_valid) ov_cnt++;
      @(posedge clk); #1;
      bus.flush = (c + 1 == 10);
      if (c + 1 == 10) bus.in_valid = 1'b0;
    end
    chk("flush_no_result", 64'(ov_cnt), 64'd0);

    // Freeze for three cycles once the product is ready.
    present(MUL, 32'hFFFF_FFFF, 0, 32'd3, 1, 2'b00, 2'b00, 4'd14, 4'b0010, 4'b1001);
    for (int c = 0; c < 42; c++) begin
      @(negedge clk);
      b = bus.busy;
      if (c >= 33 && c <= 35) begin
        chk("frz_busy", {63'd0, bus.busy}, 64'd1);
        chk("frz_valid", {63'd0, bus.out_valid}, 64'd0);
      end
      if (c == 37) begin
        chk("frz_product", {32'd0, bus.alu_res_out}, 64'hFFFF_FFFD);
        chk("frz_status", {60'd0, bus.status_out}, 64'b1010);
        chk("frz_valid_out", {63'd0, bus.out_valid}, 64'd1);
      end
      @(posedge clk); #1;
      bus.freeze = (c + 1 >= 33) && (c + 1 <= 35);
      if (!b) bus.in_valid = 1'b0;
    end

    // Reset in the middle of a multiply.
    present(MUL, 32'd2, 32'd2, 0, 0, 2'b00, 2'b00, 4'd3, 4'b0000, 4'b1000);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_mid_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_mid_res", {32'd0, bus.alu_res_out}, 64'd0);
    chk("rst_mid_en", {63'd0, bus.wb_en_out}, 64'd0);
    chk("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    exec(ADD, 32'd2, 32'd3, 0, 0, 2'b00, 2'b00, 4'd15, 4'b0000, 4'b1000);
    chk("post_rst_res", {32'd0, bus.alu_res_out}, 64'd5);
    chk("post_rst_valid", {63'd0, bus.out_valid}, 64'd1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/exe_stage_mc.md
EXE_STAGE_MC -- requirements
Module: exe_stage_mc

Interface
REQ-001 Parameter: WIDTH, 32, datapath width (>=8).
REQ-002 Parameter: REG_ADDR, 4, destination register index width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 freeze  in  1  hold output register (downstream memory stall).
REQ-006 flush  in  1  discard current EX instruction; abort any multiply.
REQ-007 in_valid  in  1  EX input holds a real instruction.
REQ-008 wb_en_in, mem_r_en_in, mem_w_en_in, status_w_en_in  in  1 each  control enables.
REQ-009 exe_cmd  in  3  000 MOV, 001 ADD, 010 SUB, 011 AND, 100 ORR, 101 EOR, 110 MUL, 111 PASS.
REQ-010 dest_in  in  REG_ADDR  destination register.
REQ-011 val_Rn, val_Rm, imm_in, MEM_wb_value, WB_wb_value  in  WIDTH each  operands and forwarded values.
REQ-012 use_imm  in  1  op2 = imm_in when 1, else forwarded Rm.
REQ-013 fwd_sel_src1, fwd_sel_src2  in  2 each  00 register, 01 WB_wb_value, 10 MEM_wb_value, 11 register.
REQ-014 status_reg_in  in  4  current NZCV.
REQ-015 pc_in  in  WIDTH; branch_offset  in  24 signed word offset.
REQ-016 branch_address  out  WIDTH  combinational pc_in + (sign-extend(branch_offset) << 2), modulo 2^WIDTH.
REQ-017 busy  out  1  upstream must hold its EX input.
REQ-018 out_valid, wb_en_out, mem_r_en_out, mem_w_en_out, status_w_en_out  out  1 each  registered.
REQ-019 alu_res_out, val_Rm_out  out  WIDTH; dest_out  out  REG_ADDR; status_out  out  4  registered.

Function
REQ-020 op1 = fwd_sel_src1-selected value; fwd_Rm = fwd_sel_src2-selected value; val_Rm_out path carries fwd_Rm.
REQ-021 MOV: op2; ADD: op1+op2; SUB: op1-op2; AND/ORR/EOR bitwise; PASS: op1; all modulo 2^WIDTH.
REQ-022 Flags: N = result MSB, Z = result==0; ADD C = carry-out, V = signed overflow; SUB C = no-borrow (op1>=op2 unsigned), V = signed overflow; all other ops keep C,V from status_reg_in.
REQ-023 FSM states IDLE, MUL, DONE; reset state IDLE.
REQ-024 IDLE, in_valid=1, exe_cmd!=MUL: output register loads result, flags, controls, out_valid=1 next edge (latency 1).
REQ-025 IDLE, in_valid=1, exe_cmd=MUL: operands, controls, dest captured; count=0; -> MUL; output register loads bubble.
REQ-026 MUL: one radix-2 shift-add step per cycle; count increments; after WIDTH steps -> DONE; product low WIDTH bits kept.
REQ-027 DONE, freeze=0: output register loads product, N/Z from product, C/V from captured status, out_valid=1; -> IDLE; EX inputs ignored.
REQ-028 DONE, freeze=1: remain in DONE.
REQ-029 busy = (IDLE & in_valid & exe_cmd=MUL) | MUL | (DONE & freeze).
REQ-030 Bubble: out_valid and all four enable outputs 0; data outputs don't-care but deterministic (hold).
REQ-031 freeze=1: output register holds all fields; FSM in MUL continues counting.
REQ-032 flush=1: FSM -> IDLE, no acceptance that cycle; output register loads bubble unless freeze=1 (then holds).
REQ-033 in_valid=0 in IDLE: output register loads bubble (unless freeze).

Reset
REQ-034 rst=1 forces immediately: state IDLE, count 0, all registered outputs 0, busy 0 (except combinational in-cycle term of REQ-029).
REQ-035 rst during MUL aborts the multiply; no result ever emitted.

Verification
REQ-036 ADD, op1=0x7FFFFFFF, imm 1, use_imm=1 -> next edge alu_res_out=0x80000000, status_out=1001, out_valid=1.
REQ-037 SUB 5-5, fwd_sel_src1=10, MEM_wb_value=5, val_Rn=9 -> alu_res_out=0, status_out Z=1,C=1,N=0,V=0.
REQ-038 MUL 7*6 (WIDTH=32) -> busy high 33 cycles, out_valid low until edge 34 after accept, then alu_res_out=42.
REQ-039 flush asserted at MUL cycle 10 -> state IDLE, busy 0 next cycle, no out_valid for that MUL.
REQ-040 freeze held 3 cycles in DONE -> outputs hold previous values, busy=1; product appears edge after freeze drops.
REQ-041 rst pulsed mid-MUL -> all outputs 0 immediately; next ADD completes normally with latency 1.
